// File: rtl/axi4lite_reg_slave_if.sv
// AXI4-Lite bus bundle shared by the register slave and whatever drives it.
// The master modport is the issuing side; the slave modport is the responding side.
interface axi4lite_reg_slave_if #(
  parameter int AW = 32
);
  logic [AW-1:0] awaddr;
  logic [2:0]    awprot;
  logic          awvalid;
  logic          awready;
  logic [31:0]   wdata;
  logic [3:0]    wstrb;
  logic          wvalid;
  logic          wready;
  logic [1:0]    bresp;
  logic          bvalid;
  logic          bready;
  logic [AW-1:0] araddr;
  logic [2:0]    arprot;
  logic          arvalid;
  logic          arready;
  logic [31:0]   rdata;
  logic [1:0]    rresp;
  logic          rvalid;
  logic          rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid,    input wready,
    input  bresp, bvalid,           output bready,
    output araddr, arprot, arvalid, input arready,
    input  rdata, rresp, rvalid,    output rready
  );

  modport slave (
    input  awaddr, awprot, awvalid, output awready,
    input  wdata, wstrb, wvalid,    output wready,
    output bresp, bvalid,           input bready,
    input  araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid,    input rready
  );
endinterface

// File: rtl/axi4lite_reg_slave.sv
// AXI4-Lite slave fronting NREG 32-bit control registers, with independently captured
// AW/W beats, byte-masked writes, SLVERR for out-of-range words and per-register write pulses.
module axi4lite_reg_slave #(
  parameter int AW   = 32,
  parameter int NREG = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  axi4lite_reg_slave_if.slave  bus,
  output logic [NREG*32-1:0]   regs_q,
  output logic [NREG-1:0]      wr_pulse
);

  localparam int         IDXW        = (NREG > 1) ? $clog2(NREG) : 1;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  function automatic logic in_range(input logic [AW-1:0] addr);
    return (addr >> 2) < AW'(NREG);
  endfunction

  logic            aw_hold_q, aw_hold_d;
  logic            w_hold_q, w_hold_d;
  logic [AW-1:0]   awaddr_q, awaddr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [3:0]      wstrb_q, wstrb_d;
  logic            bvalid_q, bvalid_d;
  logic [1:0]      bresp_q, bresp_d;
  logic            rvalid_q, rvalid_d;
  logic [31:0]     rdata_q, rdata_d;
  logic [1:0]      rresp_q, rresp_d;
  logic [31:0]     mem_q [NREG];
  logic [31:0]     mem_d [NREG];
  logic [NREG-1:0] wr_pulse_q, wr_pulse_d;

  logic            aw_hs, w_hs, ar_hs, commit;
  logic [IDXW-1:0] widx, ridx;
  logic            unused_prot;

  // Ready outputs come only from registered state, never from the valid inputs.
  assign bus.awready = !aw_hold_q && !bvalid_q;
  assign bus.wready  = !w_hold_q  && !bvalid_q;
  assign bus.arready = !rvalid_q;
  assign bus.bvalid  = bvalid_q;
  assign bus.bresp   = bresp_q;
  assign bus.rvalid  = rvalid_q;
  assign bus.rdata   = rdata_q;
  assign bus.rresp   = rresp_q;

  assign aw_hs  = bus.awvalid && bus.awready;
  assign w_hs   = bus.wvalid  && bus.wready;
  assign ar_hs  = bus.arvalid && bus.arready;
  assign commit = aw_hold_q && w_hold_q;
  assign widx   = awaddr_q[IDXW+1:2];
  assign ridx   = bus.araddr[IDXW+1:2];

  assign unused_prot = ^{bus.awprot, bus.arprot};

  // NOTE: the next-state block uses blocking assignments and defaults every _d first,
  // so no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    aw_hold_d  = aw_hold_q;
    w_hold_d   = w_hold_q;
    awaddr_d   = awaddr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    rvalid_d   = rvalid_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    mem_d      = mem_q;
    wr_pulse_d = '0;

    if (aw_hs) begin
      aw_hold_d = 1'b1;
      awaddr_d  = bus.awaddr;
    end
    if (w_hs) begin
      w_hold_d = 1'b1;
      wdata_d  = bus.wdata;
      wstrb_d  = bus.wstrb;
    end

    // Holds can only fill while bvalid is low, so commit and B release never overlap.
    if (commit) begin
      aw_hold_d = 1'b0;
      w_hold_d  = 1'b0;
      bvalid_d  = 1'b1;
      if (in_range(awaddr_q)) begin
        for (int b = 0; b < 4; b++) begin
          if (wstrb_q[b]) mem_d[widx][8*b +: 8] = wdata_q[8*b +: 8];
        end
        wr_pulse_d[widx] = 1'b1;
        bresp_d          = RESP_OKAY;
      end else begin
        bresp_d = RESP_SLVERR;
      end
    end else if (bvalid_q && bus.bready) begin
      bvalid_d = 1'b0;
    end

    // Reads sample mem_q, so a same-edge commit to the same word returns the old value.
    if (ar_hs) begin
      rvalid_d = 1'b1;
      if (in_range(bus.araddr)) begin
        rdata_d = mem_q[ridx];
        rresp_d = RESP_OKAY;
      end else begin
        rdata_d = '0;
        rresp_d = RESP_SLVERR;
      end
    end else if (rvalid_q && bus.rready) begin
      rvalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      aw_hold_q  <= 1'b0;
      w_hold_q   <= 1'b0;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
      wr_pulse_q <= '0;
      // NOTE: the register bank is reset like any other flop because fabric logic
      // relies on every control register reading zero after reset.
      for (int k = 0; k < NREG; k++) mem_q[k] <= '0;
    end else begin
      aw_hold_q  <= aw_hold_d;
      w_hold_q   <= w_hold_d;
      awaddr_q   <= awaddr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
      wr_pulse_q <= wr_pulse_d;
      for (int k = 0; k < NREG; k++) mem_q[k] <= mem_d[k];
    end
  end

  for (genvar k = 0; k < NREG; k++) begin : g_flat
    assign regs_q[32*k +: 32] = mem_q[k];
  end
  assign wr_pulse = wr_pulse_q;

endmodule

// File: tb/tb_axi4lite_reg_slave.sv
// Self-checking bench for axi4lite_reg_slave: directed scenarios plus randomized traffic
// compared against a word-array model of the register bank.
module tb_axi4lite_reg_slave;
  localparam int AW   = 32;
  localparam int NREG = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [NREG*32-1:0] regs_q;
  logic [NREG-1:0]    wr_pulse;

  int checks = 0;
  int errors = 0;
  logic [31:0] model [NREG];

  axi4lite_reg_slave_if #(.AW(AW)) bus ();

  axi4lite_reg_slave #(.AW(AW), .NREG(NREG)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus.slave),
    .regs_q   (regs_q),
    .wr_pulse (wr_pulse)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [NREG*32-1:0] model_flat();
    logic [NREG*32-1:0] v;
    for (int k = 0; k < NREG; k++) v[32*k +: 32] = model[k];
    return v;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data,
                                        input logic [3:0] strb);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = data[8*b +: 8];
    return r;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Full write transaction: AW presented after aw_dly cycles, W after w_dly cycles, bready high.
  task automatic write_txn(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int aw_dly, input int w_dly,
                           input string tag);
    bit aw_done, w_done, aw_now, w_now, in_rng;
    int cyc, lat, pulses, idx;
    logic [NREG-1:0] pulse_or, exp_pulse;
    logic [1:0] exp_resp;
    idx       = int'(addr >> 2);
    in_rng    = idx < NREG;
    exp_resp  = in_rng ? 2'b00 : 2'b10;
    exp_pulse = '0;
    if (in_rng) begin
      exp_pulse[idx] = 1'b1;
      model[idx] = merge(model[idx], data, strb);
    end
    aw_done = 0; w_done = 0; cyc = 0; pulses = 0; pulse_or = '0;
    bus.bready = 1'b1;
    while (!(aw_done && w_done) && cyc < 40) begin
      bus.awvalid = !aw_done && (cyc >= aw_dly);
      bus.awaddr  = addr;
      bus.awprot  = 3'($urandom);
      bus.wvalid  = !w_done && (cyc >= w_dly);
      bus.wdata   = data;
      bus.wstrb   = strb;
      aw_now = bus.awvalid && bus.awready;
      w_now  = bus.wvalid && bus.wready;
      next_cycle();
      aw_done |= aw_now;
      w_done  |= w_now;
      if (wr_pulse != '0) begin pulses++; pulse_or |= wr_pulse; end
      cyc++;
    end
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    checks++;
    if (!(aw_done && w_done)) begin
      errors++;
      $display("FAIL %s_handshake: aw_done=%0d w_done=%0d required both 1", tag, aw_done, w_done);
    end
    lat = 0;
    while (!bus.bvalid && lat < 20) begin
      next_cycle();
      lat++;
      if (wr_pulse != '0) begin pulses++; pulse_or |= wr_pulse; end
    end
    checks++;
    if (lat !== 1) begin
      errors++;
      $display("FAIL %s_b_latency: got %0d cycles required 1", tag, lat);
    end
    checks++;
    if (bus.bresp !== exp_resp) begin
      errors++;
      $display("FAIL %s_bresp: got %b required %b", tag, bus.bresp, exp_resp);
    end
    next_cycle();
    if (wr_pulse != '0) begin pulses++; pulse_or |= wr_pulse; end
    checks++;
    if (bus.bvalid !== 1'b0) begin
      errors++;
      $display("FAIL %s_b_release: bvalid=%b required 0", tag, bus.bvalid);
    end
    checks++;
    if (pulse_or !== exp_pulse || pulses !== (in_rng ? 1 : 0)) begin
      errors++;
      $display("FAIL %s_wr_pulse: bits %b over %0d cycles required %b over %0d", tag,
               pulse_or, pulses, exp_pulse, in_rng ? 1 : 0);
    end
    checks++;
    if (regs_q !== model_flat()) begin
      errors++;
      $display("FAIL %s_regs: got %h required %h", tag, regs_q, model_flat());
    end
  endtask

  task automatic read_txn(input logic [31:0] addr, input string tag);
    int cyc, idx;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
    idx      = int'(addr >> 2);
    exp_data = (idx < NREG) ? model[idx] : 32'h0;
    exp_resp = (idx < NREG) ? 2'b00 : 2'b10;
    bus.rready  = 1'b1;
    bus.araddr  = addr;
    bus.arprot  = 3'($urandom);
    bus.arvalid = 1'b1;
    cyc = 0;
    while (!bus.arready && cyc < 20) begin next_cycle(); cyc++; end
    next_cycle();
    bus.arvalid = 1'b0;
    checks++;
    if (bus.rvalid !== 1'b1 || bus.rdata !== exp_data || bus.rresp !== exp_resp) begin
      errors++;
      $display("FAIL %s_read: rvalid=%b rdata=%h rresp=%b required 1 %h %b", tag,
               bus.rvalid, bus.rdata, bus.rresp, exp_data, exp_resp);
    end
    next_cycle();
    checks++;
    if (bus.rvalid !== 1'b0) begin
      errors++;
      $display("FAIL %s_r_release: rvalid=%b required 0", tag, bus.rvalid);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus.awready, bus.wready, bus.arready} !== 3'b111 || bus.bvalid !== 1'b0 ||
        bus.rvalid !== 1'b0 || bus.bresp !== 2'b00 || bus.rdata !== 32'h0 ||
        bus.rresp !== 2'b00 || regs_q !== '0 || wr_pulse !== '0) begin
      errors++;
      $display("FAIL reset_state: rdy=%b bvalid=%b rvalid=%b regs=%h pulse=%b required 111 0 0 0 0",
               {bus.awready, bus.wready, bus.arready}, bus.bvalid, bus.rvalid, regs_q, wr_pulse);
    end
    reset = 1'b0;
    next_cycle();
    checks++;
    if ({bus.awready, bus.wready, bus.arready} !== 3'b111) begin
      errors++;
      $display("FAIL reset_release_ready: got %b required 111", {bus.awready, bus.wready, bus.arready});
    end
    for (int k = 0; k < NREG; k++) read_txn(32'(4 * k), "reset_read");
  endtask

  task automatic test_basic_write();
    write_txn(32'h8, 32'hA5A5_1234, 4'hF, 0, 0, "basic");
    read_txn(32'h8, "basic");
  endtask

  task automatic test_w_before_aw();
    write_txn(32'h4, 32'hFFFF_FFFF, 4'hF, 0, 0, "wfirst_prep");
    write_txn(32'h4, 32'h1122_3344, 4'b0101, 3, 0, "wfirst");
    checks++;
    if (regs_q[63:32] !== 32'hFF22_FF44) begin
      errors++;
      $display("FAIL wfirst_value: got %h required ff22ff44", regs_q[63:32]);
    end
    repeat (3) begin
      next_cycle();
      checks++;
      if (bus.bvalid !== 1'b0) begin
        errors++;
        $display("FAIL wfirst_extra_b: bvalid=%b required 0", bus.bvalid);
      end
    end
  endtask

  task automatic test_out_of_range();
    write_txn(32'h20, 32'hDEAD_BEEF, 4'hF, 0, 0, "oor");
    read_txn(32'h20, "oor");
  endtask

  task automatic test_backpressure();
    logic [31:0] wd, exp_rd;
    wd     = $urandom;
    exp_rd = model[2];
    bus.bready  = 1'b0;
    bus.rready  = 1'b0;
    bus.awaddr  = 32'hC;  bus.awvalid = 1'b1;
    bus.wdata   = wd;     bus.wstrb   = 4'hF; bus.wvalid = 1'b1;
    bus.araddr  = 32'h8;  bus.arvalid = 1'b1;
    next_cycle();
    bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
    next_cycle();
    model[3] = wd;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (bus.bvalid !== 1'b1 || bus.bresp !== 2'b00 || bus.rvalid !== 1'b1 ||
          bus.rdata !== exp_rd || bus.rresp !== 2'b00 ||
          {bus.awready, bus.wready, bus.arready} !== 3'b000) begin
        errors++;
        $display("FAIL stall_%0d: b=%b/%b r=%b/%h/%b rdy=%b required 1/00 1/%h/00 000", i,
                 bus.bvalid, bus.bresp, bus.rvalid, bus.rdata, bus.rresp,
                 {bus.awready, bus.wready, bus.arready}, exp_rd);
      end
      next_cycle();
    end
    bus.bready = 1'b1;
    bus.rready = 1'b1;
    next_cycle();
    checks++;
    if (bus.bvalid !== 1'b0 || bus.rvalid !== 1'b0 ||
        {bus.awready, bus.wready, bus.arready} !== 3'b111 || regs_q !== model_flat()) begin
      errors++;
      $display("FAIL stall_release: bvalid=%b rvalid=%b rdy=%b regs=%h required 0 0 111 %h",
               bus.bvalid, bus.rvalid, {bus.awready, bus.wready, bus.arready}, regs_q, model_flat());
    end
  endtask

  task automatic test_same_edge();
    logic [31:0] wd, old;
    wd  = $urandom;
    old = model[5];
    bus.bready = 1'b1; bus.rready = 1'b1;
    bus.awaddr = 32'h14; bus.awvalid = 1'b1;
    bus.wdata  = wd; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    next_cycle();
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    bus.araddr  = 32'h14; bus.arvalid = 1'b1;
    next_cycle();
    bus.arvalid = 1'b0;
    model[5] = wd;
    checks++;
    if (bus.rvalid !== 1'b1 || bus.rdata !== old || bus.bvalid !== 1'b1) begin
      errors++;
      $display("FAIL same_edge_old: rvalid=%b rdata=%h bvalid=%b required 1 %h 1",
               bus.rvalid, bus.rdata, bus.bvalid, old);
    end
    next_cycle();
    read_txn(32'h14, "same_edge_new");
  endtask

  task automatic test_reset_mid();
    bus.wdata = 32'hCAFE_F00D; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    bus.awvalid = 1'b0;
    next_cycle();
    bus.wvalid = 1'b0;
    checks++;
    if (bus.wready !== 1'b0) begin
      errors++;
      $display("FAIL mid_w_held: wready=%b required 0", bus.wready);
    end
    #2 reset = 1'b1;
    #1;
    for (int k = 0; k < NREG; k++) model[k] = '0;
    checks++;
    if (bus.wready !== 1'b1 || regs_q !== '0) begin
      errors++;
      $display("FAIL mid_async_reset: wready=%b regs=%h required 1 0", bus.wready, regs_q);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (2) begin
      next_cycle();
      checks++;
      if (bus.bvalid !== 1'b0 || wr_pulse !== '0) begin
        errors++;
        $display("FAIL mid_no_response: bvalid=%b pulse=%b required 0 0", bus.bvalid, wr_pulse);
      end
    end
    write_txn(32'h18, 32'h0BAD_C0DE, 4'hF, 0, 0, "mid_fresh");
  endtask

  task automatic test_random();
    logic [31:0] addr;
    for (int i = 0; i < 60; i++) begin
      addr = 32'($urandom_range(0, 11) * 4 + $urandom_range(0, 3));
      if ($urandom_range(0, 1) == 0)
        write_txn(addr, $urandom, 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), "rnd_wr");
      else
        read_txn(addr, "rnd_rd");
    end
  endtask

  initial begin
    bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
    bus.wdata  = '0; bus.wstrb  = '0; bus.wvalid  = 1'b0;
    bus.bready = 1'b0;
    bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0;
    bus.rready = 1'b0;
    for (int k = 0; k < NREG; k++) model[k] = '0;

    test_reset();
    test_basic_write();
    test_w_before_aw();
    test_out_of_range();
    test_backpressure();
    test_same_edge();
    test_reset_mid();
    test_random();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
